// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared sizes and FSM state type for the CPU program RAM.
package cpu_mem_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;
endpackage

// File: rtl/ram_sp_8kx16.sv
// ram_sp_8kx16: one write port, one registered read-first read port; rd_clr forces the read register to 0.
module ram_sp_8kx16 #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] rdata_q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rd_clr ? '0 : mem[raddr];
  end
endmodule

// File: rtl/cpu_ram_responder.sv
// cpu_ram_responder: CPU RAM with program-load FSM; define RAM_ZERO_CLEAR_EN to zero the RAM after reset.
module cpu_ram_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_toRAM,
  input  logic [DATA_W-1:0] data_toRAM,
  input  logic              wrEn,
  output logic [DATA_W-1:0] data_fromRAM,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_rst,
  output logic              load_err
);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
`ifdef RAM_ZERO_CLEAR_EN
  localparam state_t RST_STATE = ST_CLEAR;
  logic [ADDR_W-1:0] clr_q, clr_d;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, waddr;
  logic [DATA_W-1:0] wdata;
  logic err_q, err_d, cpu_rst_q, cpu_rst_d, we;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    err_d = err_q;
    we = 1'b0;
    waddr = addr_toRAM;
    wdata = data_toRAM;
`ifdef RAM_ZERO_CLEAR_EN
    clr_d = clr_q;
`endif
    case (state_q)
      ST_RUN: begin
        we = wrEn;
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d = '0;
          err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        we = load_valid;
        waddr = ptr_q;
        wdata = load_data;
        if (load_valid) begin
          // Overflow ends the load without wrapping the pointer.
          if (load_last) state_d = ST_RUN;
          else if (ptr_q == PTR_MAX) begin
            state_d = ST_RUN;
            err_d = 1'b1;
          end
          if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
        end
      end
`ifdef RAM_ZERO_CLEAR_EN
      ST_CLEAR: begin
        we = 1'b1;
        waddr = clr_q;
        wdata = '0;
        clr_d = clr_q + 1'b1;
        if (clr_q == PTR_MAX) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      state_d = RST_STATE;
      ptr_d = '0;
      err_d = 1'b0;
      we = 1'b0;
`ifdef RAM_ZERO_CLEAR_EN
      clr_d = '0;
`endif
    end
    cpu_rst_d = rst || (state_d != ST_RUN);
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q <= ptr_d;
    err_q <= err_d;
    cpu_rst_q <= cpu_rst_d;
`ifdef RAM_ZERO_CLEAR_EN
    clr_q <= clr_d;
`endif
  end
  ram_sp_8kx16 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(addr_toRAM),
    .rd_clr(rst || (state_q != ST_RUN)),
    .rdata_q(data_fromRAM)
  );
  assign load_ready = (state_q == ST_LOAD);
  assign cpu_rst = cpu_rst_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_cpu_ram_responder.sv
// tb_cpu_ram_responder: directed checks of RUN access, loads, overflow and reset abort.
module tb_cpu_ram_responder;
  logic clk = 1'b0, rst = 1'b1, wrEn = 1'b0;
  logic load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [12:0] addr_toRAM = '0;
  logic [15:0] data_toRAM = '0, load_data = '0, data_fromRAM;
  logic load_ready, cpu_rst, load_err;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  cpu_ram_responder dut (
    .clk(clk), .rst(rst), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM),
    .wrEn(wrEn), .data_fromRAM(data_fromRAM), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .cpu_rst(cpu_rst), .load_err(load_err)
  );
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [12:0] a, input logic [15:0] e, input string tag);
    addr_toRAM = a;
    wrEn = 1'b0;
    step();
    chk(tag, data_fromRAM, e);
  endtask
  task automatic wr(input logic [12:0] a, input logic [15:0] d);
    addr_toRAM = a;
    data_toRAM = d;
    wrEn = 1'b1;
    step();
    wrEn = 1'b0;
  endtask
  task automatic wait_run();
    int n = 0;
    while (cpu_rst !== 1'b0 && n < 10000) begin
      step();
      n++;
    end
    chk("run_timeout", {15'd0, cpu_rst}, 16'd0);
  endtask
  initial begin
    step();
    step();
    chk("rst_data", data_fromRAM, 16'h0);
    chk("rst_err", {15'd0, load_err}, 16'd0);
    chk("rst_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    chk("rst_ready", {15'd0, load_ready}, 16'd0);
    rst = 1'b0;
    wait_run();
    wr(13'd5, 16'h1234);
    rd(13'd5, 16'h1234, "rd5_first");
    wr(13'd5, 16'hBEEF);
    chk("rd_during_wr", data_fromRAM, 16'h1234);
    rd(13'd5, 16'hBEEF, "rd5_new");
    wr(13'd7, 16'h0777);
    wr(13'd3, 16'h0333);
    // short gapped load with a stray CPU write to address 7
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ld_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    chk("ld_ready", {15'd0, load_ready}, 16'd1);
    addr_toRAM = 13'd7;
    data_toRAM = 16'hFFFF;
    wrEn = 1'b1;
    load_valid = 1'b1; load_data = 16'hA000; step();
    load_valid = 1'b0; step();
    chk("ld_data_zero", data_fromRAM, 16'h0);
    load_valid = 1'b1; load_data = 16'hA001; step();
    load_valid = 1'b0; step();
    chk("ld_cpu_rst_gap", {15'd0, cpu_rst}, 16'd1);
    wrEn = 1'b0;
    load_valid = 1'b1; load_data = 16'hA002; load_last = 1'b1; step();
    load_valid = 1'b0; load_last = 1'b0;
    chk("ld_cpu_rst_drop", {15'd0, cpu_rst}, 16'd0);
    chk("ld_err_clear", {15'd0, load_err}, 16'd0);
    rd(13'd0, 16'hA000, "ld_m0");
    rd(13'd1, 16'hA001, "ld_m1");
    rd(13'd2, 16'hA002, "ld_m2");
    rd(13'd3, 16'h0333, "ld_m3_kept");
    rd(13'd7, 16'h0777, "ld_m7_kept");
    rd(13'd5, 16'hBEEF, "ld_m5_kept");
    // full-size load without load_last overflows at the last address
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 8191; i++) begin
      load_data = 16'(i + 256);
      step();
    end
    chk("ovf_err_early", {15'd0, load_err}, 16'd0);
    chk("ovf_ready_early", {15'd0, load_ready}, 16'd1);
    load_data = 16'h20FF;
    step();
    load_valid = 1'b0;
    chk("ovf_err", {15'd0, load_err}, 16'd1);
    chk("ovf_ready", {15'd0, load_ready}, 16'd0);
    chk("ovf_cpu_rst", {15'd0, cpu_rst}, 16'd0);
    rd(13'd0, 16'h0100, "ovf_m0");
    rd(13'd8191, 16'h20FF, "ovf_mlast");
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ovf_err_cleared", {15'd0, load_err}, 16'd0);
    // reset after two of four words aborts the load
    load_valid = 1'b1; load_data = 16'hB000; step();
    load_data = 16'hB001; step();
    load_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("abort_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    rst = 1'b0;
    wait_run();
`ifdef RAM_ZERO_CLEAR_EN
    rd(13'd0, 16'h0, "clr_m0");
    rd(13'd1, 16'h0, "clr_m1");
    rd(13'd2, 16'h0, "clr_m2");
    rd(13'd8191, 16'h0, "clr_mlast");
`else
    rd(13'd0, 16'hB000, "abort_m0");
    rd(13'd1, 16'hB001, "abort_m1");
    rd(13'd2, 16'h0102, "abort_m2_kept");
    rd(13'd8191, 16'h20FF, "abort_mlast_kept");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/cpu_ram_responder.md
CPU_RAM_RESPONDER -- requirements
Module: cpu_ram_responder

Interface
REQ-001 Parameter ADDR_W, default 13, word-address width.
REQ-002 Parameter DATA_W, default 16, word width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 addr_toRAM  input  ADDR_W  CPU word address.
REQ-006 data_toRAM  input  DATA_W  CPU write data.
REQ-007 wrEn  input  1  CPU write enable, sampled at clk edge.
REQ-008 data_fromRAM  output  DATA_W  registered read data.
REQ-009 load_start  input  1  one-cycle pulse, begins program load.
REQ-010 load_valid  input  1  loader word valid.
REQ-011 load_data  input  DATA_W  loader word.
REQ-012 load_last  input  1  marks final loader word, qualified by load_valid.
REQ-013 load_ready  output  1  high only in LOAD state.
REQ-014 cpu_rst  output  1  CPU reset request, high in every state except RUN.
REQ-015 load_err  output  1  sticky load-overflow flag.

Function
REQ-016 Storage SHALL be 2^ADDR_W words of DATA_W bits, single write port, single read port.
REQ-017 Read latency SHALL be exactly 1 cycle: data_fromRAM at edge N+1 equals mem[addr_toRAM sampled at edge N].
REQ-018 Read-during-write to the same address SHALL return old data (read-first).
REQ-019 FSM states: CLEAR, LOAD, RUN; encoding is free.
REQ-020 RUN: wrEn=1 writes data_toRAM to mem[addr_toRAM] at the edge; the read port is active.
REQ-021 CLEAR/LOAD: wrEn SHALL be ignored and data_fromRAM SHALL hold 0.
REQ-022 RUN with load_start=1 SHALL go to LOAD, clear the load pointer to 0, and raise cpu_rst the next cycle.
REQ-023 load_start outside RUN SHALL be ignored.
REQ-024 LOAD: a word transfers when load_valid && load_ready; each transfer writes mem[ptr]=load_data and then increments ptr.
REQ-025 A transfer with load_last=1 SHALL go to RUN; cpu_rst SHALL drop the following cycle.
REQ-026 A transfer at ptr=2^ADDR_W-1 with load_last=0 SHALL set load_err and go to RUN; ptr SHALL not wrap.
REQ-027 load_err SHALL clear only on rst or on the next accepted load_start.
REQ-028 Words not written during a load SHALL retain their prior contents.

Reset
REQ-029 rst SHALL set data_fromRAM=0, load_err=0, ptr=0, cpu_rst=1.
REQ-030 On rst the next state SHALL be CLEAR if RAM_ZERO_CLEAR_EN is defined, otherwise RUN.
REQ-031 rst mid-LOAD SHALL abort the load; words already written SHALL remain unless CLEAR runs.
REQ-032 rst SHALL not alter memory contents directly.

Configuration
REQ-033 Macro RAM_ZERO_CLEAR_EN: when defined, CLEAR writes 0 to one word per cycle, addresses 0..2^ADDR_W-1, and then goes to RUN (2^ADDR_W cycles with cpu_rst high).
REQ-034 When RAM_ZERO_CLEAR_EN is absent, the CLEAR state and its counter SHALL not be built, and reset goes directly to RUN.

Structure
REQ-035 Package cpu_mem_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state typedef.
REQ-036 Storage SHALL be a sub-module ram_sp_8kx16 (1 write port, registered read); write source selection and the FSM live in cpu_ram_responder.

Verification
REQ-037 RUN: write 0x1234 to address 5 with wrEn=1, then read address 5 -> data_fromRAM=0x1234 exactly one cycle after the address.
REQ-038 Same-cycle write of 0xBEEF and read at address 5 holding 0x1234 -> 0x1234 returned; next read -> 0xBEEF.
REQ-039 load_start, then 3 words 0xA000/0xA001/0xA002 (last on the third) with load_valid gapped -> mem[0..2] correct, cpu_rst high throughout, low one cycle after the last word, load_err=0.
REQ-040 Load of 8192 words with no load_last -> load_err=1, state RUN; a subsequent load_start clears load_err.
REQ-041 rst asserted after 2 of 4 load words -> mem[0..1] hold the new data; with RAM_ZERO_CLEAR_EN defined, all words read 0 after 8192 cycles with cpu_rst high.
REQ-042 wrEn=1 with data 0xFFFF to address 7 during LOAD -> mem[7] unchanged.
